// File: rtl/enemy_formation_ctrl.sv
// -----------------------------------------------------------------------------
// enemy_formation_ctrl
//
// This block controls how the enemy formation moves. It produces the formation
// origin and the animation select used by every enemy sprite and collision
// block. The formation steps sideways once per period. At a screen edge it
// moves down and reverses direction. The period shortens as kills build up.
// Time advances only on frame_tick. The march stops for good once the
// formation has landed.
//
// Ports
//   clk        : pixel clock, the only clock
//   reset      : synchronous, active-high; overrides every other input
//   frame_tick : one-cycle pulse per video frame
//   enable     : 1 = march runs, 0 = frozen
//   kill       : one-cycle pulse per enemy destroyed
//   posX/posY  : formation origin (10 bit)
//   troca      : animation frame select; toggles on every step
//   step       : one-cycle pulse on each move or descend
//   landed     : sticky; formation reached Y_LIMIT
//   period     : current frames-per-step (6 bit)
// -----------------------------------------------------------------------------
module enemy_formation_ctrl #(
    parameter int unsigned X_START       = 40,
    parameter int unsigned Y_START       = 40,
    parameter int unsigned X_MIN         = 8,
    parameter int unsigned X_MAX         = 600,
    parameter int unsigned STEP_X        = 4,
    parameter int unsigned STEP_Y        = 16,
    parameter int unsigned Y_LIMIT       = 440,
    parameter int unsigned FRAMES_INIT   = 30,
    parameter int unsigned FRAMES_MIN    = 4,
    parameter int unsigned SPEEDUP_KILLS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       kill,
    output logic [9:0] posX,
    output logic [9:0] posY,
    output logic       troca,
    output logic       step,
    output logic       landed,
    output logic [5:0] period
);

    // Edge and landing tests use 11 bits, so adding a step cannot wrap.
    localparam logic [10:0] X_MIN_W     = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W     = 11'(X_MAX);
    localparam logic [10:0] STEP_X_W    = 11'(STEP_X);
    localparam logic [10:0] STEP_Y_W    = 11'(STEP_Y);
    localparam logic [10:0] Y_LIMIT_W   = 11'(Y_LIMIT);
    localparam logic [6:0]  FR_MIN_W    = 7'(FRAMES_MIN);
    localparam int unsigned KCW         = (SPEEDUP_KILLS > 1) ? $clog2(SPEEDUP_KILLS) : 1;
    localparam logic [KCW-1:0] KILL_LAST = KCW'(SPEEDUP_KILLS - 1);

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LANDED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [9:0]     pos_x_q, pos_x_d;
    logic [9:0]     pos_y_q, pos_y_d;
    logic           troca_q, troca_d;
    logic           step_q, step_d;
    logic           landed_q, landed_d;
    logic [5:0]     period_q, period_d;
    logic           dir_q, dir_d;
    logic [5:0]     frame_cnt_q, frame_cnt_d;
    logic [KCW-1:0] kill_cnt_q, kill_cnt_d;

    logic           step_evt_s;
    logic           at_edge_s;
    logic [10:0]    desc_y_s;

    // Next-state logic for motion, state machine and speed-up.
    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        troca_d     = troca_q;
        step_d      = 1'b0;
        landed_d    = landed_q;
        period_d    = period_q;
        dir_d       = dir_q;
        frame_cnt_d = frame_cnt_q;
        kill_cnt_d  = kill_cnt_q;

        // frame_cnt + 1 >= period has the same meaning as frame_cnt >= period - 1.
        // It is written this way so it cannot underflow when period is small.
        step_evt_s = (state_q == ST_RUN) && enable && frame_tick &&
                     (({1'b0, frame_cnt_q} + 7'd1) >= {1'b0, period_q});

        if (dir_q == DIR_RIGHT) begin
            at_edge_s = (({1'b0, pos_x_q} + STEP_X_W) > X_MAX_W);
        end else begin
            at_edge_s = ({1'b0, pos_x_q} < (X_MIN_W + STEP_X_W));
        end

        desc_y_s = {1'b0, pos_y_q} + STEP_Y_W;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (step_evt_s) begin
                    frame_cnt_d = 6'd0;
                    troca_d     = ~troca_q;
                    step_d      = 1'b1;
                    if (at_edge_s) begin
                        pos_y_d = desc_y_s[9:0];
                        dir_d   = ~dir_q;
                        if (desc_y_s >= Y_LIMIT_W) begin
                            landed_d = 1'b1;
                            state_d  = ST_LANDED;
                        end else begin
                            state_d  = ST_RUN;
                        end
                    end else if (dir_q == DIR_RIGHT) begin
                        pos_x_d = pos_x_q + STEP_X_W[9:0];
                    end else begin
                        pos_x_d = pos_x_q - STEP_X_W[9:0];
                    end
                end else if (enable && frame_tick) begin
                    frame_cnt_d = frame_cnt_q + 6'd1;
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            ST_LANDED: begin
                state_d = ST_LANDED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Speed-up writes period_d directly. A step in this same cycle was
        // already decided from period_q, so the new period only takes effect
        // from the next cycle.
        if ((state_q != ST_LANDED) && kill) begin
            if (kill_cnt_q == KILL_LAST) begin
                kill_cnt_d = {KCW{1'b0}};
                if ({1'b0, period_q} < (FR_MIN_W + 7'd2)) begin
                    period_d = FR_MIN_W[5:0];
                end else begin
                    period_d = period_q - 6'd2;
                end
            end else begin
                kill_cnt_d = kill_cnt_q + {{(KCW-1){1'b0}}, 1'b1};
            end
        end else begin
            kill_cnt_d = kill_cnt_q;
        end
    end

    // State register; reset discards any update in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pos_x_q     <= 10'(X_START);
            pos_y_q     <= 10'(Y_START);
            troca_q     <= 1'b0;
            step_q      <= 1'b0;
            landed_q    <= 1'b0;
            period_q    <= 6'(FRAMES_INIT);
            dir_q       <= DIR_RIGHT;
            frame_cnt_q <= 6'd0;
            kill_cnt_q  <= {KCW{1'b0}};
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            troca_q     <= troca_d;
            step_q      <= step_d;
            landed_q    <= landed_d;
            period_q    <= period_d;
            dir_q       <= dir_d;
            frame_cnt_q <= frame_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign posX   = pos_x_q;
    assign posY   = pos_y_q;
    assign troca  = troca_q;
    assign step   = step_q;
    assign landed = landed_q;
    assign period = period_q;

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// -----------------------------------------------------------------------------
// tb_enemy_formation_ctrl
//
// Directed bench for enemy_formation_ctrl. It uses a narrow playfield
// (X_MAX=48, Y_LIMIT=72) so that edge descents and landing happen within a
// few steps. Expected values are worked out by hand from the start position
// (40,40), a 30-frame initial period, 4 px horizontal and 16 px vertical steps.
// -----------------------------------------------------------------------------
module tb_enemy_formation_ctrl;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       enable;
    logic       kill;
    logic [9:0] posX;
    logic [9:0] posY;
    logic       troca;
    logic       step;
    logic       landed;
    logic [5:0] period;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int step_cnt   = 0;

    enemy_formation_ctrl #(
        .X_START(40), .Y_START(40), .X_MIN(8), .X_MAX(48),
        .STEP_X(4), .STEP_Y(16), .Y_LIMIT(72),
        .FRAMES_INIT(30), .FRAMES_MIN(4), .SPEEDUP_KILLS(4)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .kill(kill), .posX(posX), .posY(posY), .troca(troca), .step(step),
        .landed(landed), .period(period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count the cycles in which step is high, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (step === 1'b1) step_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic kills(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) kill = 1'b1;
            @(negedge clk) kill = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; enable = 1'b0; kill = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("rst_posX", posX, 40);
        check_val("rst_posY", posY, 40);
        check_val("rst_troca", troca, 0);
        check_val("rst_step", step, 0);
        check_val("rst_landed", landed, 0);
        check_val("rst_period", period, 30);

        // IDLE ignores frame_tick.
        ticks(35);
        check_val("idle_posX", posX, 40);
        check_val("idle_steps", step_cnt, 0);

        // First step after the 30th tick.
        @(negedge clk) enable = 1'b1;
        ticks(29);
        check_val("t1_nostep_cnt", step_cnt, 0);
        check_val("t1_nostep_posX", posX, 40);
        ticks(1);
        check_val("t1_step", step, 1);
        check_val("t1_posX", posX, 44);
        check_val("t1_troca", troca, 1);
        @(negedge clk);
        check_val("t1_step_low", step, 0);
        check_val("t1_step_width", step_cnt, 1);

        // Right edge at 48, then descend and reverse.
        ticks(30);
        check_val("t2_posX48", posX, 48);
        check_val("t2_troca0", troca, 0);
        ticks(30);
        check_val("t2_desc_posY", posY, 56);
        check_val("t2_desc_posX", posX, 48);
        check_val("t2_desc_troca", troca, 1);
        ticks(30);
        check_val("t2_left_posX", posX, 44);
        check_val("t2_left_posY", posY, 56);
        check_val("t2_steps", step_cnt, 4);

        // Freeze with frame_cnt=10: 20 ticks remain after re-enable.
        ticks(10);
        @(negedge clk) enable = 1'b0;
        ticks(50);
        check_val("t6_frz_posX", posX, 44);
        check_val("t6_frz_posY", posY, 56);
        check_val("t6_frz_troca", troca, 0);
        check_val("t6_frz_steps", step_cnt, 4);
        @(negedge clk) enable = 1'b1;
        ticks(19);
        check_val("t6_pre_steps", step_cnt, 4);
        ticks(1);
        check_val("t6_posX", posX, 40);
        check_val("t6_steps", step_cnt, 5);

        // Kill coincident with a step at kill_cnt=3.
        kills(3);
        check_val("t4_period_pre", period, 30);
        ticks(29);
        @(negedge clk) begin frame_tick = 1'b1; kill = 1'b1; end
        @(negedge clk) begin frame_tick = 1'b0; kill = 1'b0; end
        check_val("t4_step", step, 1);
        check_val("t4_posX", posX, 36);
        check_val("t4_period", period, 28);
        ticks(27);
        check_val("t4_fc0_nostep", posX, 36);
        ticks(1);
        check_val("t4_fc0_step", posX, 32);
        check_val("t4_steps", step_cnt, 7);

        // Speed-up cadence and floor.
        kills(3);
        check_val("t3_period_3k", period, 28);
        kills(1);
        check_val("t3_period_4k", period, 26);
        kills(40);
        check_val("t3_period_44k", period, 6);
        kills(4);
        check_val("t3_period_floor", period, 4);
        kills(8);
        check_val("t3_period_sat", period, 4);

        // March left to X_MIN, then descend onto Y_LIMIT.
        ticks(24);
        check_val("t5_posX8", posX, 8);
        check_val("t5_posY56", posY, 56);
        check_val("t5_not_landed", landed, 0);
        ticks(4);
        check_val("t5_posY72", posY, 72);
        check_val("t5_posX_hold", posX, 8);
        check_val("t5_landed", landed, 1);
        check_val("t5_troca", troca, 0);
        check_val("t5_steps", step_cnt, 14);

        // LANDED ignores everything but reset.
        @(negedge clk) enable = 1'b0;
        ticks(3);
        @(negedge clk) enable = 1'b1;
        ticks(20);
        kills(8);
        check_val("t5_hold_posX", posX, 8);
        check_val("t5_hold_posY", posY, 72);
        check_val("t5_hold_landed", landed, 1);
        check_val("t5_hold_troca", troca, 0);
        check_val("t5_hold_steps", step_cnt, 14);

        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check_val("t5_rst_posX", posX, 40);
        check_val("t5_rst_posY", posY, 40);
        check_val("t5_rst_landed", landed, 0);
        check_val("t5_rst_period", period, 30);

        // Reset on the step tick discards the step.
        ticks(29);
        @(negedge clk) begin frame_tick = 1'b1; reset = 1'b1; end
        @(negedge clk) begin frame_tick = 1'b0; reset = 1'b0; end
        check_val("rs_posX", posX, 40);
        check_val("rs_troca", troca, 0);
        check_val("rs_step", step, 0);
        ticks(29);
        check_val("rs_fc_cleared", step_cnt, 14);
        ticks(1);
        check_val("rs_next_posX", posX, 44);
        check_val("rs_next_steps", step_cnt, 15);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
